// File: rtl/st_commit_buffer_pkg.sv
// rtl/st_commit_buffer_pkg.sv - shared types for the store commit buffer
package st_commit_buffer_pkg;

    localparam int ST_PLEN = 34;
    localparam int ST_XLEN = 32;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } st_size_e;

    typedef struct packed {
        logic [ST_PLEN-1:0]   paddr;
        logic [ST_XLEN-1:0]   data;
        logic [ST_XLEN/8-1:0] be;
        st_size_e             size;
        logic                 valid;
    } st_entry_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/st_fifo.sv
// rtl/st_fifo.sv - circular store-entry queue with a per-entry word-offset view
module st_fifo
    import st_commit_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  st_entry_t                push_entry,
    input  logic                     pop,
    output st_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [9:0]               entry_word [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    st_entry_t     mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // Only valid entries are ever stored, so the valid flag doubles as the push qualifier.
    assign do_push = push && push_entry.valid && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[head_ptr];

    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = mem[i].valid;
            entry_word[i]  = mem[i].paddr[11:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else begin
            if (do_pop) begin
                mem[head_ptr].valid <= 1'b0;
                head_ptr            <= head_ptr + 1'b1;
            end
            if (do_push) begin
                mem[tail_ptr] <= push_entry;
                tail_ptr      <= tail_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/st_commit_buffer.sv
// rtl/st_commit_buffer.sv - speculative and commit store queues with req/gnt drain
module st_commit_buffer
    import st_commit_buffer_pkg::*;
#(
    parameter int SPEC_DEPTH   = 4,
    parameter int COMMIT_DEPTH = 4,
    parameter int PLEN         = ST_PLEN,
    parameter int XLEN         = ST_XLEN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [PLEN-1:0]   paddr_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [1:0]        data_size_i,
    input  logic              commit_i,
    output logic              commit_ready_o,
    input  logic [11:0]       page_offset_i,
    output logic              page_offset_matches_o,
    output logic              no_st_pending_o,
    output logic              store_buffer_empty_o,
    output logic              req_o,
    output logic [PLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [1:0]        size_o,
    input  logic              gnt_i
);

    localparam int SCW = $clog2(SPEC_DEPTH) + 1;
    localparam int CCW = $clog2(COMMIT_DEPTH) + 1;

    st_entry_t         spec_in;
    st_entry_t         spec_head;
    st_entry_t         commit_head;
    logic              spec_push;
    logic              spec_full;
    logic              spec_empty;
    logic [SCW-1:0]    spec_count;
    logic [SPEC_DEPTH-1:0]   spec_valid;
    logic [9:0]        spec_word [SPEC_DEPTH];
    logic              commit_push;
    logic              commit_pop;
    logic              commit_full;
    logic              commit_empty;
    logic [CCW-1:0]    commit_count;
    logic [COMMIT_DEPTH-1:0] commit_valid;
    logic [9:0]        commit_word [COMMIT_DEPTH];
    drain_state_t      state;
    logic              req_active;
    logic              unused_offset_lsb;

    assign spec_in = '{paddr: paddr_i, data: data_i, be: be_i,
                       size: st_size_e'(data_size_i), valid: 1'b1};

    // Status reflects current occupancy only; a same-cycle pop gives no extra credit.
    assign ready_o        = !spec_full;
    assign commit_ready_o = !commit_full;

    // A store arriving together with flush is discarded along with the queue.
    assign spec_push   = valid_i && !spec_full && !flush_i;
    assign commit_push = commit_i && !commit_full && (spec_count != '0);
    assign commit_pop  = (state == DRAIN_REQ) && gnt_i;

    st_fifo #(.DEPTH(SPEC_DEPTH)) u_spec_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .flush       (flush_i),
        .push        (spec_push),
        .push_entry  (spec_in),
        .pop         (commit_push),
        .head        (spec_head),
        .full        (spec_full),
        .empty       (spec_empty),
        .count       (spec_count),
        .entry_valid (spec_valid),
        .entry_word  (spec_word)
    );

    st_fifo #(.DEPTH(COMMIT_DEPTH)) u_commit_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .flush       (1'b0),
        .push        (commit_push),
        .push_entry  (spec_head),
        .pop         (commit_pop),
        .head        (commit_head),
        .full        (commit_full),
        .empty       (commit_empty),
        .count       (commit_count),
        .entry_valid (commit_valid),
        .entry_word  (commit_word)
    );

    // Leave REQ only when the granted entry was the last one and nothing new arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= DRAIN_IDLE;
        end else begin
            case (state)
                DRAIN_IDLE: if (!commit_empty) state <= DRAIN_REQ;
                DRAIN_REQ:  if (commit_pop && (commit_count == CCW'(1)) && !commit_push)
                                state <= DRAIN_IDLE;
                default:    state <= DRAIN_IDLE;
            endcase
        end
    end

    assign req_active = (state == DRAIN_REQ) && commit_head.valid;
    assign req_o      = req_active;
    assign addr_o     = req_active ? commit_head.paddr : '0;
    assign wdata_o    = req_active ? commit_head.data  : '0;
    assign be_o       = req_active ? commit_head.be    : '0;
    assign size_o     = req_active ? 2'(commit_head.size) : 2'b00;

    assign no_st_pending_o      = commit_empty && (state == DRAIN_IDLE);
    assign store_buffer_empty_o = spec_empty && commit_empty;

    // Hazard granularity is the 32-bit word, so the two byte-offset bits are ignored.
    assign unused_offset_lsb = ^page_offset_i[1:0];

    always_comb begin
        page_offset_matches_o = 1'b0;
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            if (spec_valid[i] && (spec_word[i] == page_offset_i[11:2]))
                page_offset_matches_o = 1'b1;
        end
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            if (commit_valid[i] && (commit_word[i] == page_offset_i[11:2]))
                page_offset_matches_o = 1'b1;
        end
    end

endmodule
